// File: rtl/exe_mem_pipe_pkg.sv
// ---------------------------------------------------------------------------
// exe_mem_pipe_pkg
//
// Purpose:
//   Shared definitions for the EXE->MEM pipeline register and the other
//   pipeline stages that exchange the same control bundle.
//
// Contents:
//   DSIZE_DEF  default data/address width (maddr, rdata2)
//   ASIZE_DEF  default regfile write-back address width
//   CTRL_W     width of the control bundle
//   ctrl_t     control bundle, MSB first: memwrite, memread, memtoreg, wen
//   gate_ctrl  forces the control bundle to zero when its beat is not valid
// ---------------------------------------------------------------------------
package exe_mem_pipe_pkg;

    localparam int DSIZE_DEF = 32;
    localparam int ASIZE_DEF = 5;
    localparam int CTRL_W    = 4;

    // Bit order matters: every stage packs and unpacks the bundle through
    // this type, so the layout is defined exactly once here.
    typedef struct packed {
        logic memwrite;
        logic memread;
        logic memtoreg;
        logic wen;
    } ctrl_t;

    // A stale control bundle sitting in an empty register must never reach
    // memory or the register file, so every consumer sees zeros unless the
    // beat that carries it is valid.
    function automatic ctrl_t gate_ctrl(input ctrl_t ctrl, input logic valid);
        ctrl_t gated;
        gated = '0;
        if (valid) begin
            gated = ctrl;
        end
        return gated;
    endfunction

endpackage

// File: rtl/exe_mem_pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//
// Purpose:
//   One pipeline slot: a valid flag plus a payload register. Used for both
//   the main output register and the optional skid register of
//   exe_mem_pipe.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears valid and payload
//   load       update the slot this cycle (valid takes valid_in)
//   valid_in   new valid value when load is high
//   clear      squash the held beat; wins over load
//   data_in    payload captured when load & valid_in
//   valid_out  slot holds a beat
//   data_out   held payload (keeps its last value while the slot is empty)
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             valid_in,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state for the slot. The payload is only overwritten when a real
    // beat arrives, so an emptied slot keeps presenting its last payload and
    // downstream never sees the fields toggle on bubbles. A clear drops the
    // beat even if a load is requested in the same cycle, which is how a
    // flush discards the incoming beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = valid_in;
            if (valid_in) begin
                data_d = data_in;
            end
        end
        if (clear) begin
            valid_d = 1'b0;
        end
    end

    // State register. Reset has priority over everything, so anything
    // presented while rst is high is thrown away and the payload returns to
    // all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/exe_mem_pipe.sv
// ---------------------------------------------------------------------------
// exe_mem_pipe
//
// Purpose:
//   EXE->MEM pipeline register with valid/ready flow control, flush and a
//   load-pending tap for the hazard unit. Carries the memory address,
//   write-back register address, store data and the control bundle from the
//   ALU stage to the data-memory stage.
//
// Build option:
//   EXMEM_SKID_EN  when defined, a second (skid) slot absorbs one extra beat
//                  and in_ready comes straight from a register, breaking the
//                  out_ready->in_ready combinational path. When undefined,
//                  a single slot is used and in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush                          squash held beats and the incoming beat
//   in_valid / in_ready            upstream handshake
//   maddr_in, waddr_in, rdata2_in  payload from EXE
//   memwrite_in .. wen_in          control bits from EXE
//   out_valid / out_ready          downstream handshake
//   maddr_out, waddr_out,
//   rdata2_out                     registered payload
//   memwrite_out .. wen_out        control bits, zero unless out_valid
//   load_pending                   a valid load sits at the output
// ---------------------------------------------------------------------------
module exe_mem_pipe
    import exe_mem_pipe_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] maddr_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic             memwrite_in,
    input  logic             memread_in,
    input  logic             memtoreg_in,
    input  logic             wen_in,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] maddr_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [DSIZE-1:0] rdata2_out,
    output logic             memwrite_out,
    output logic             memread_out,
    output logic             memtoreg_out,
    output logic             wen_out,

    output logic             load_pending
);

    // Payload layout inside a slot, MSB first: maddr, waddr, rdata2, ctrl.
    localparam int PW         = DSIZE + ASIZE + DSIZE + CTRL_W;
    localparam int MADDR_LSB  = ASIZE + DSIZE + CTRL_W;
    localparam int WADDR_LSB  = DSIZE + CTRL_W;
    localparam int RDATA2_LSB = CTRL_W;

    ctrl_t          ctrl_in;
    ctrl_t          ctrl_held;
    ctrl_t          ctrl_gated;
    logic [PW-1:0]  payload_in;

    logic           in_xfer;
    logic           out_xfer;
    logic           m_take;

    logic           m_load;
    logic           m_valid_in;
    logic [PW-1:0]  m_data_in;
    logic           m_valid;
    logic [PW-1:0]  m_data;

`ifdef EXMEM_SKID_EN
    logic           s_load;
    logic           s_valid_in;
    logic           s_valid;
    logic [PW-1:0]  s_data;
`endif

    // Bundle the incoming beat into one flat word so both slots can treat
    // it as opaque payload.
    always_comb begin
        ctrl_in          = '0;
        ctrl_in.memwrite = memwrite_in;
        ctrl_in.memread  = memread_in;
        ctrl_in.memtoreg = memtoreg_in;
        ctrl_in.wen      = wen_in;
        payload_in       = {maddr_in, waddr_in, rdata2_in, ctrl_in};
    end

`ifdef EXMEM_SKID_EN
    // With the skid slot, upstream may send whenever the skid slot is free.
    // s_valid is a flop output, so out_ready has no combinational route to
    // in_ready; the skid slot is what catches the beat that is already in
    // flight when MEM stalls.
    assign in_ready = !s_valid;
`else
    // Single-slot build: accept when the slot is empty or is being emptied
    // this cycle. This keeps full throughput at the cost of a combinational
    // path from out_ready to in_ready.
    assign in_ready = !m_valid || out_ready;
`endif

    // Handshake bookkeeping and slot steering.
    //
    // The main slot reloads whenever it is empty or its beat is being taken
    // by MEM. The older beat in the skid slot always goes first, which keeps
    // delivery strictly in order. If nothing is available the main slot
    // simply goes empty.
    //
    // The skid slot only captures a beat when one arrives while the main
    // slot is full and stalled. It can never be overwritten while full,
    // because in_ready is low for exactly that case. It empties when its
    // beat moves into the main slot.
    //
    // Flush is applied as a clear on both slots; the clear wins over any
    // load, so the incoming beat of a flush cycle is dropped too, while an
    // output transfer in that cycle has already happened on the wire.
    always_comb begin
        in_xfer    = in_valid && in_ready;
        out_xfer   = m_valid && out_ready;
        m_take     = !m_valid || out_xfer;

        m_load     = m_take;
        m_valid_in = in_xfer;
        m_data_in  = payload_in;

`ifdef EXMEM_SKID_EN
        s_valid_in = in_xfer && m_valid && !out_xfer;
        s_load     = s_valid_in || (s_valid && m_take);
        if (s_valid) begin
            m_valid_in = 1'b1;
            m_data_in  = s_data;
        end
`endif
    end

    pipe_slot #(
        .WIDTH (PW)
    ) u_main_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (m_load),
        .valid_in  (m_valid_in),
        .clear     (flush),
        .data_in   (m_data_in),
        .valid_out (m_valid),
        .data_out  (m_data)
    );

`ifdef EXMEM_SKID_EN
    pipe_slot #(
        .WIDTH (PW)
    ) u_skid_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load),
        .valid_in  (s_valid_in),
        .clear     (flush),
        .data_in   (payload_in),
        .valid_out (s_valid),
        .data_out  (s_data)
    );
`endif

    // Output unpacking. Payload fields come straight from the main slot and
    // hold their last value across bubbles; the control bits are gated by
    // out_valid so an empty stage can never trigger a write. load_pending
    // uses the gated memread, so it is high exactly while a valid load is
    // waiting in this stage.
    always_comb begin
        ctrl_held    = ctrl_t'(m_data[CTRL_W-1:0]);
        ctrl_gated   = gate_ctrl(ctrl_held, m_valid);

        out_valid    = m_valid;
        maddr_out    = m_data[MADDR_LSB  +: DSIZE];
        waddr_out    = m_data[WADDR_LSB  +: ASIZE];
        rdata2_out   = m_data[RDATA2_LSB +: DSIZE];

        memwrite_out = ctrl_gated.memwrite;
        memread_out  = ctrl_gated.memread;
        memtoreg_out = ctrl_gated.memtoreg;
        wen_out      = ctrl_gated.wen;

        load_pending = ctrl_gated.memread;
    end

endmodule

// File: tb/tb_exe_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_pipe
//
// Directed, table-driven bench for exe_mem_pipe. Each table row gives the
// inputs for one cycle and the outputs expected during that same cycle
// (before the edge that consumes those inputs). Rows that differ between the
// single-slot and skid builds are selected with EXMEM_SKID_EN.
// ---------------------------------------------------------------------------
module tb_exe_mem_pipe;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_ST   = 4'b1000;
    localparam logic [3:0] C_LD   = 4'b0111;
    localparam logic [3:0] C_ALU  = 4'b0001;
    localparam logic [3:0] C_MTR  = 4'b0011;

`ifdef EXMEM_SKID_EN
    localparam logic SKID_ON = 1'b1;
`else
    localparam logic SKID_ON = 1'b0;
`endif

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] ma;
        logic [4:0]  wa;
        logic [3:0]  c;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic        chk;
        logic [31:0] e_ma;
        logic [4:0]  e_wa;
        logic [3:0]  e_c;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] maddr_in;
    logic [ASIZE-1:0] waddr_in;
    logic [DSIZE-1:0] rdata2_in;
    logic             memwrite_in;
    logic             memread_in;
    logic             memtoreg_in;
    logic             wen_in;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] maddr_out;
    logic [ASIZE-1:0] waddr_out;
    logic [DSIZE-1:0] rdata2_out;
    logic             memwrite_out;
    logic             memread_out;
    logic             memtoreg_out;
    logic             wen_out;
    logic             load_pending;

    int pass_cnt;
    int total_cnt;
    vec_t vecs[$];

    exe_mem_pipe #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .maddr_in     (maddr_in),
        .waddr_in     (waddr_in),
        .rdata2_in    (rdata2_in),
        .memwrite_in  (memwrite_in),
        .memread_in   (memread_in),
        .memtoreg_in  (memtoreg_in),
        .wen_in       (wen_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .maddr_out    (maddr_out),
        .waddr_out    (waddr_out),
        .rdata2_out   (rdata2_out),
        .memwrite_out (memwrite_out),
        .memread_out  (memread_out),
        .memtoreg_out (memtoreg_out),
        .wen_out      (wen_out),
        .load_pending (load_pending)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row builder. Store data is derived from the address so the payload
    // path for rdata2 is checked without another table column.
    function automatic vec_t mk(input logic fl, input logic iv,
                                input logic [31:0] ma, input logic [4:0] wa,
                                input logic [3:0] c, input logic ordy,
                                input logic e_ir, input logic e_ov,
                                input logic chk, input logic [31:0] e_ma,
                                input logic [4:0] e_wa, input logic [3:0] e_c);
        vec_t v;
        v.fl   = fl;   v.iv   = iv;   v.ma   = ma;   v.wa   = wa;
        v.c    = c;    v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
        v.chk  = chk;  v.e_ma = e_ma; v.e_wa = e_wa; v.e_c  = e_c;
        return v;
    endfunction

    // Waits for the falling edge and drives one row's inputs.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        flush       = v.fl;
        in_valid    = v.iv;
        maddr_in    = v.ma;
        waddr_in    = v.wa;
        rdata2_in   = ~v.ma;
        memwrite_in = v.c[3];
        memread_in  = v.c[2];
        memtoreg_in = v.c[1];
        wen_in      = v.c[0];
        out_ready   = v.ordy;
    endtask

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Compares all outputs against one row's expectations.
    task automatic checkRow(input int idx, input vec_t v);
        logic [3:0] ctrl_out;
        ctrl_out = {memwrite_out, memread_out, memtoreg_out, wen_out};
        checkOutput($sformatf("r%0d in_ready", idx), 32'(in_ready), 32'(v.e_ir));
        checkOutput($sformatf("r%0d out_valid", idx), 32'(out_valid), 32'(v.e_ov));
        checkOutput($sformatf("r%0d ctrl", idx), 32'(ctrl_out), 32'(v.e_c));
        checkOutput($sformatf("r%0d load_pending", idx), 32'(load_pending),
                    32'(v.e_ov & v.e_c[2]));
        if (v.chk) begin
            checkOutput($sformatf("r%0d maddr", idx), maddr_out, v.e_ma);
            checkOutput($sformatf("r%0d waddr", idx), 32'(waddr_out), 32'(v.e_wa));
            checkOutput($sformatf("r%0d rdata2", idx), rdata2_out, ~v.e_ma);
        end
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;

        // Reset for two edges with a beat presented; it must be discarded.
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b1;
        maddr_in    = 32'h1234;
        waddr_in    = 5'd3;
        rdata2_in   = 32'hDEAD_BEEF;
        memwrite_in = 1'b1;
        memread_in  = 1'b1;
        memtoreg_in = 1'b1;
        wen_in      = 1'b1;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        in_valid    = 1'b0;
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset maddr", maddr_out, 32'd0);
        checkOutput("reset waddr", 32'(waddr_out), 32'd0);
        checkOutput("reset rdata2", rdata2_out, 32'd0);
        checkOutput("reset ctrl", 32'({memwrite_out, memread_out, memtoreg_out, wen_out}), 32'd0);
        checkOutput("reset load_pending", 32'(load_pending), 32'd0);

        // Streaming at full rate: each beat appears one cycle after it is
        // accepted; the last payload is held once the stage empties.
        vecs.push_back(mk(0,1,32'h10,5'd1,C_ST ,1, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(0,1,32'h14,5'd5,C_LD ,1, 1,1,1,32'h10,5'd1,C_ST));
        vecs.push_back(mk(0,1,32'h18,5'd2,C_ALU,1, 1,1,1,32'h14,5'd5,C_LD));
        vecs.push_back(mk(0,1,32'h1C,5'd3,C_MTR,1, 1,1,1,32'h18,5'd2,C_ALU));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,1,1,32'h1C,5'd3,C_MTR));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,1,32'h1C,5'd3,C_NONE));

`ifdef EXMEM_SKID_EN
        // Backpressure: A0 held in M, A4 caught in S, in_ready drops the
        // cycle after S fills, A8 waits upstream until S drains.
        vecs.push_back(mk(0,1,32'hA0,5'd6,C_ALU,0, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(0,1,32'hA4,5'd7,C_ALU,0, 1,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA8,5'd8,C_ALU,0, 0,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA8,5'd8,C_ALU,0, 0,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA8,5'd8,C_ALU,1, 0,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA8,5'd8,C_ALU,1, 1,1,1,32'hA4,5'd7,C_ALU));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,1,1,32'hA8,5'd8,C_ALU));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,0,32'h0 ,5'd0,C_NONE));
        // Flush with a store in M and a beat in S.
        vecs.push_back(mk(0,1,32'h40,5'd9 ,C_ST ,0, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(0,1,32'h44,5'd10,C_ALU,0, 1,1,1,32'h40,5'd9,C_ST));
        vecs.push_back(mk(1,1,32'h48,5'd11,C_ALU,0, 0,1,1,32'h40,5'd9,C_ST));
`else
        // Backpressure: in_ready follows out_ready combinationally while M
        // is full; A4 waits upstream, order is preserved.
        vecs.push_back(mk(0,1,32'hA0,5'd6,C_ALU,0, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(0,1,32'hA4,5'd7,C_ALU,0, 0,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA4,5'd7,C_ALU,0, 0,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA4,5'd7,C_ALU,1, 1,1,1,32'hA0,5'd6,C_ALU));
        vecs.push_back(mk(0,1,32'hA8,5'd8,C_ALU,1, 1,1,1,32'hA4,5'd7,C_ALU));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,1,1,32'hA8,5'd8,C_ALU));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,0,32'h0 ,5'd0,C_NONE));
        // Flush with a stalled store in M.
        vecs.push_back(mk(0,1,32'h40,5'd9 ,C_ST ,0, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(1,1,32'h44,5'd10,C_ALU,0, 0,1,1,32'h40,5'd9,C_ST));
`endif
        // After the flush nothing is valid, and a beat offered during a
        // flush into an empty stage is dropped as well.
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,0,32'h0,5'd0,C_NONE));
        vecs.push_back(mk(1,1,32'h4C,5'd12,C_ST ,1, 1,0,0,32'h0,5'd0,C_NONE));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,0,32'h0,5'd0,C_NONE));
        // Load hazard tap: high exactly while the load is held at the output.
        vecs.push_back(mk(0,1,32'h80,5'd5,C_LD ,0, 1,0,0,32'h0 ,5'd0,C_NONE));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,0, SKID_ON,1,1,32'h80,5'd5,C_LD));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,1,1,32'h80,5'd5,C_LD));
        vecs.push_back(mk(0,0,32'h0 ,5'd0,C_NONE,1, 1,0,1,32'h80,5'd5,C_NONE));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
        end

        // Reset in the middle of a stream: the held load is dropped and the
        // beat presented during reset never lands.
        applyStimulus(mk(0,1,32'h90,5'd4,C_LD,0, 1,0,0,32'h0,5'd0,C_NONE));
        applyStimulus(mk(0,1,32'h94,5'd7,C_ST,0, 1,0,0,32'h0,5'd0,C_NONE));
        rst = 1'b1;
        #1;
        checkOutput("midrst pre out_valid", 32'(out_valid), 32'd1);
        checkOutput("midrst pre maddr", maddr_out, 32'h90);
        checkOutput("midrst pre load_pending", 32'(load_pending), 32'd1);
        applyStimulus(mk(0,0,32'h0,5'd0,C_NONE,1, 1,0,0,32'h0,5'd0,C_NONE));
        rst = 1'b0;
        #1;
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst maddr", maddr_out, 32'd0);
        checkOutput("midrst load_pending", 32'(load_pending), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
